// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer
//   Consumer end of the render pixel interface. Takes the renderer's pixel
//   stream (drawing, x, y, cidx), clips off-screen pixels, turns surviving
//   pixels into linear framebuffer addresses and queues them in a small FIFO
//   that feeds the framebuffer write port. The renderer is throttled through
//   oe, and done pulses once every pixel of a shape has been committed after
//   the renderer signals end of stream.
//
//   Handshakes:
//     renderer side : a pixel is taken in every cycle with drawing=1; the
//                     renderer only asserts drawing while oe=1. oe depends on
//                     registered state (and rst) only, never on drawing.
//     memory side   : fb_we is the valid, fb_ready the ready; a write
//                     transfers when fb_we & fb_ready. While fb_ready=0 the
//                     request (fb_we, fb_addr, fb_din) holds stable.
//
//   Pipeline: S1 registers the pixel and evaluates clipping, S2 forms the
//   address and pushes unclipped pixels into the FIFO, the FIFO head drives
//   the write port. A pixel drawn in cycle N appears on the port in N+3.
//
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     drawing, x, y, cidx renderer pixel stream (x/y signed)
//     end_in              renderer done; its rising edge ends the stream
//     oe                  writer can take a pixel this cycle
//     fb_we/addr/din      framebuffer write request
//     fb_ready            framebuffer accepts the write this cycle
//     busy                pixels in flight or end-of-stream pending
//     done                one-cycle pulse: all pixels of the stream written
//     clip_count          (FB_CLIP_STATS_EN only) clipped pixels this shape
//
//   Build option: define FB_CLIP_STATS_EN to add the clip_count output and
//   its saturating counter. Without it the port and logic are absent.

module fb_pixel_writer #(
    parameter int CORDW      = 16,
    parameter int CIDXW      = 4,
    parameter int FB_WIDTH   = 320,
    parameter int FB_HEIGHT  = 180,
    parameter int FB_ADDRW   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    drawing,
    input  logic signed [CORDW-1:0] x,
    input  logic signed [CORDW-1:0] y,
    input  logic [CIDXW-1:0]        cidx,
    input  logic                    end_in,
    output logic                    oe,
    output logic                    fb_we,
    output logic [FB_ADDRW-1:0]     fb_addr,
    output logic [CIDXW-1:0]        fb_din,
    input  logic                    fb_ready,
    output logic                    busy,
    output logic                    done
`ifdef FB_CLIP_STATS_EN
    ,
    output logic [15:0]             clip_count
`endif
);

    localparam int PTRW = $clog2(FIFO_DEPTH);
    localparam int CNTW = PTRW + 1;
    // Occupancy is FIFO count plus two pipeline stages.
    localparam int OCCW = $clog2(FIFO_DEPTH + 3);

    localparam logic signed [CORDW-1:0] X_LIM = CORDW'(FB_WIDTH);
    localparam logic signed [CORDW-1:0] Y_LIM = CORDW'(FB_HEIGHT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_DONE = 2'd2
    } end_state_t;

    // ---------------------------------------------------------------
    // Pipeline registers
    // ---------------------------------------------------------------
    logic                    s1_valid_q;
    logic signed [CORDW-1:0] s1_x_q;
    logic signed [CORDW-1:0] s1_y_q;
    logic [CIDXW-1:0]        s1_cidx_q;
    logic                    s1_clip;

    logic                    s2_valid_q;
    logic                    s2_clip_q;
    logic signed [CORDW-1:0] s2_x_q;
    logic signed [CORDW-1:0] s2_y_q;
    logic [CIDXW-1:0]        s2_cidx_q;
    logic [FB_ADDRW-1:0]     s2_addr;

    // ---------------------------------------------------------------
    // FIFO state
    // ---------------------------------------------------------------
    logic [FB_ADDRW-1:0] mem_addr_q [FIFO_DEPTH];
    logic [CIDXW-1:0]    mem_din_q  [FIFO_DEPTH];
    logic [PTRW-1:0]     wr_ptr_q;
    logic [PTRW-1:0]     rd_ptr_q;
    logic [CNTW-1:0]     count_q;
    logic [CNTW-1:0]     count_d;

    logic                accept;
    logic                push;
    logic                pop;
    logic [OCCW-1:0]     occ;
    logic [OCCW-1:0]     occ_d;

    end_state_t          state_q;
    end_state_t          state_d;
    logic                end_in_q;
    logic                end_edge;

    // ---------------------------------------------------------------
    // Flow control
    // ---------------------------------------------------------------
    // Every accepted pixel holds one slot from acceptance until it is
    // written or dropped, so limiting occ to FIFO_DEPTH guarantees the
    // FIFO can never overflow even though clipping happens downstream.
    assign occ    = OCCW'(count_q) + OCCW'(s1_valid_q) + OCCW'(s2_valid_q);
    assign oe     = !rst && (occ < OCCW'(FIFO_DEPTH));
    assign accept = drawing & oe;

    // ---------------------------------------------------------------
    // S1: register pixel; S1 comb: clip test
    // ---------------------------------------------------------------
    assign s1_clip = s1_x_q[CORDW-1] | s1_y_q[CORDW-1] |
                     (s1_x_q >= X_LIM) | (s1_y_q >= Y_LIM);

    // Product is taken modulo 2**FB_ADDRW; operands are truncated first,
    // which gives the same low bits as truncating the full product.
    assign s2_addr = FB_ADDRW'($unsigned(s2_y_q)) * FB_ADDRW'(FB_WIDTH) +
                     FB_ADDRW'($unsigned(s2_x_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_cidx_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_clip_q  <= 1'b0;
            s2_x_q     <= '0;
            s2_y_q     <= '0;
            s2_cidx_q  <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_x_q    <= x;
                s1_y_q    <= y;
                s1_cidx_q <= cidx;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_clip_q <= s1_clip;
                s2_x_q    <= s1_x_q;
                s2_y_q    <= s1_y_q;
                s2_cidx_q <= s1_cidx_q;
            end
        end
    end

    // ---------------------------------------------------------------
    // Write FIFO
    // ---------------------------------------------------------------
    assign push    = s2_valid_q & ~s2_clip_q;
    assign fb_we   = !rst && (count_q != '0);
    assign pop     = fb_we & fb_ready;
    assign fb_addr = mem_addr_q[rd_ptr_q];
    assign fb_din  = mem_din_q[rd_ptr_q];
    assign count_d = count_q + CNTW'(push) - CNTW'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_addr_q[i] <= '0;
                mem_din_q[i]  <= '0;
            end
        end else begin
            if (push) begin
                mem_addr_q[wr_ptr_q] <= s2_addr;
                mem_din_q[wr_ptr_q]  <= s2_cidx_q;
                wr_ptr_q             <= wr_ptr_q + PTRW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTRW'(1);
            end
            count_q <= count_d;
        end
    end

    // ---------------------------------------------------------------
    // End-of-stream tracking
    // ---------------------------------------------------------------
    // occ_d is the occupancy the next cycle will see. Testing it instead of
    // occ lets done rise in the cycle right after the final write transfer.
    assign occ_d    = OCCW'(count_d) + OCCW'(accept) + OCCW'(s1_valid_q);
    assign end_edge = end_in & ~end_in_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            end_in_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            end_in_q <= end_in;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (end_edge) state_d = ST_PEND;
            end
            ST_PEND: begin
                if (occ_d == '0) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = end_edge ? ST_PEND : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign done = (state_q == ST_DONE);
    assign busy = (occ != '0) | (state_q == ST_PEND);

`ifdef FB_CLIP_STATS_EN
    // ---------------------------------------------------------------
    // Clip statistics: per-shape count of dropped pixels
    // ---------------------------------------------------------------
    logic [15:0] clip_count_q;

    always_ff @(posedge clk) begin
        if (rst || done) begin
            clip_count_q <= '0;
        end else if (s2_valid_q && s2_clip_q && (clip_count_q != 16'hFFFF)) begin
            clip_count_q <= clip_count_q + 16'd1;
        end
    end

    assign clip_count = clip_count_q;
`endif

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Testbench for fb_pixel_writer: directed scenarios with literal expectations
// plus a long randomized run, all checked every cycle against a behavioural
// model holding the accepted pixels as a timestamped list.

module tb_fb_pixel_writer;

    // ---------------------------------------------------------------
    // Clock / reset / DUT
    // ---------------------------------------------------------------
    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               drawing;
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic [3:0]         cidx;
    logic               end_in;
    logic               oe;
    logic               fb_we;
    logic [15:0]        fb_addr;
    logic [3:0]         fb_din;
    logic               fb_ready;
    logic               busy;
    logic               done;
`ifdef FB_CLIP_STATS_EN
    logic [15:0]        clip_count;
`endif

    fb_pixel_writer dut (
        .clk        (clk),
        .rst        (rst),
        .drawing    (drawing),
        .x          (x),
        .y          (y),
        .cidx       (cidx),
        .end_in     (end_in),
        .oe         (oe),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_din     (fb_din),
        .fb_ready   (fb_ready),
        .busy       (busy),
        .done       (done)
`ifdef FB_CLIP_STATS_EN
        ,
        .clip_count (clip_count)
`endif
    );

    // ---------------------------------------------------------------
    // Check bookkeeping
    // ---------------------------------------------------------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // ---------------------------------------------------------------
    // Behavioural model: every accepted pixel with its acceptance cycle.
    // An unclipped pixel is writable 3 cycles after acceptance and leaves
    // when written; a clipped one is counted in S2 (2 cycles after) and
    // leaves then. Occupancy is simply the length of the list.
    // ---------------------------------------------------------------
    typedef struct {
        logic [15:0] addr;
        logic [3:0]  cidx;
        bit          clip;
        int          t_acc;
    } pix_t;

    pix_t m_q[$];
    bit   m_pend;
    bit   m_done;
    bit   m_prev_end;
    int   m_clip;
    int   cyc = 0;

    always @(negedge clk) begin : compare
        int   occ;
        int   occ_next;
        int   head;
        int   nclip;
        int   xi;
        int   yi;
        bit   exp_we;
        bit   edge_seen;
        pix_t p;

        if (rst) begin
            chk("rst_oe", 32'(oe), 32'(0));
            chk("rst_we", 32'(fb_we), 32'(0));
            m_q.delete();
            m_pend     = 1'b0;
            m_done     = 1'b0;
            m_prev_end = 1'b0;
            m_clip     = 0;
        end else begin
            occ  = m_q.size();
            head = -1;
            foreach (m_q[i]) if (head < 0 && !m_q[i].clip) head = i;
            exp_we = (head >= 0) && (m_q[head].t_acc + 3 <= cyc);

            chk("oe", 32'(oe), 32'(occ < 4));
            chk("fb_we", 32'(fb_we), 32'(exp_we));
            if (exp_we) begin
                chk("fb_addr", 32'(fb_addr), 32'(m_q[head].addr));
                chk("fb_din", 32'(fb_din), 32'(m_q[head].cidx));
            end
            chk("busy", 32'(busy), 32'((occ != 0) || m_pend));
            chk("done", 32'(done), 32'(m_done));
`ifdef FB_CLIP_STATS_EN
            chk("clip_count", 32'(clip_count), 32'(m_clip));
`endif

            // advance model to next cycle
            if (exp_we && fb_ready) m_q.delete(head);
            nclip = 0;
            for (int i = m_q.size() - 1; i >= 0; i--) begin
                if (m_q[i].clip && (m_q[i].t_acc + 2 == cyc)) begin
                    nclip++;
                    m_q.delete(i);
                end
            end
            if (m_done) m_clip = 0;
            else        m_clip = (m_clip + nclip > 65535) ? 65535 : m_clip + nclip;

            if (drawing) begin
                xi      = int'(x);
                yi      = int'(y);
                p.clip  = (xi < 0) || (yi < 0) || (xi >= 320) || (yi >= 180);
                p.addr  = 16'(yi * 320 + xi);
                p.cidx  = cidx;
                p.t_acc = cyc;
                m_q.push_back(p);
            end
            occ_next = m_q.size();

            edge_seen  = end_in && !m_prev_end;
            m_prev_end = end_in;
            if (m_done) begin
                m_done = 1'b0;
                m_pend = edge_seen;
            end else if (m_pend) begin
                if (occ_next == 0) begin
                    m_pend = 1'b0;
                    m_done = 1'b1;
                end
            end else begin
                m_pend = edge_seen;
            end
        end
        cyc++;
    end

    // ---------------------------------------------------------------
    // Driver tasks
    // ---------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One pixel at cycle N, then watch N..N+5: write expected only at N+3.
    task automatic pix_probe(input int xv, input int yv, input int cv,
                             input int exp_addr, input string tag);
        tick();
        drawing = 1'b1;
        x       = 16'(xv);
        y       = 16'(yv);
        cidx    = 4'(cv);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 3) begin
                chk({tag, "_we"}, 32'(fb_we), 32'(1));
                chk({tag, "_addr"}, 32'(fb_addr), 32'(exp_addr));
                chk({tag, "_din"}, 32'(fb_din), 32'(cv));
            end else begin
                chk({tag, "_we_off"}, 32'(fb_we), 32'(0));
            end
            tick();
            drawing = 1'b0;
        end
    endtask

    // ---------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------
    initial begin
        int wr_list[$];
        int sent;
        int nw;
        int bad;
        int stall_chg;
        int stall_first;
        int last_wr;
        int done_c;
        int ndone;
        int nwe;
        int tmp;
        bit saw_low;
        bit have_stall;
        bit busy_at_done;
        bit busy_any;
        logic [15:0] stall_addr;
        int edge_x[4];

        rst      = 1'b1;
        drawing  = 1'b0;
        end_in   = 1'b0;
        fb_ready = 1'b1;
        x        = '0;
        y        = '0;
        cidx     = '0;
        edge_x   = '{-1, 0, 319, 320};

        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_oe", 32'(oe), 32'(1));
        chk("post_rst_we", 32'(fb_we), 32'(0));
        chk("post_rst_addr", 32'(fb_addr), 32'(0));
        chk("post_rst_din", 32'(fb_din), 32'(0));
        chk("post_rst_busy", 32'(busy), 32'(0));
        chk("post_rst_done", 32'(done), 32'(0));

        // single pixels with hand-computed addresses
        pix_probe(70, 0, 3, 70, "t1");
        pix_probe(249, 179, 3, 57529, "t2a");
        pix_probe(319, 179, 3, 57599, "t2b");

        // four off-screen pixels back to back
        tick(); drawing = 1'b1; x = -16'sd1;  y = 16'sd5;   cidx = 4'd1;
        tick();                 x = 16'sd320; y = 16'sd0;
        tick();                 x = 16'sd0;   y = 16'sd180;
        tick();                 x = 16'sd10;  y = -16'sd3;
        tick(); drawing = 1'b0;
        nwe = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (fb_we) nwe++;
            tick();
        end
        chk("t3_no_writes", 32'(nwe), 32'(0));
`ifdef FB_CLIP_STATS_EN
        @(negedge clk);
        chk("t3_clip_count", 32'(clip_count), 32'(4));
        tick();
`endif

        // 20-pixel stream with fb_ready low for stream cycles 3..12
        sent = 0; nw = 0; saw_low = 1'b0; stall_chg = 0; have_stall = 1'b0;
        stall_addr = '0; stall_first = -1;
        for (int c = 0; c < 300 && nw < 20; c++) begin
            tick();
            fb_ready = !(c >= 3 && c <= 12);
            if (sent < 20 && oe) begin
                drawing = 1'b1;
                x       = 16'(sent);
                y       = 16'sd0;
                cidx    = 4'(sent);
                sent++;
            end else begin
                drawing = 1'b0;
            end
            @(negedge clk);
            if (!oe) saw_low = 1'b1;
            if (fb_we && fb_ready) begin
                wr_list.push_back(int'(fb_addr));
                nw++;
            end
            if (fb_we && !fb_ready) begin
                if (have_stall && fb_addr != stall_addr) stall_chg++;
                if (!have_stall) stall_first = int'(fb_addr);
                stall_addr = fb_addr;
                have_stall = 1'b1;
            end
        end
        tick();
        drawing  = 1'b0;
        fb_ready = 1'b1;
        chk("t4_count", 32'(wr_list.size()), 32'(20));
        bad = 0;
        foreach (wr_list[i]) if (wr_list[i] != i) bad++;
        chk("t4_order", 32'(bad), 32'(0));
        chk("t4_oe_throttled", 32'(saw_low), 32'(1));
        chk("t4_stall_stable", 32'(stall_chg), 32'(0));
        chk("t4_stall_head", 32'(stall_first), 32'(0));

        // three pixels, end_in held high from the last one
        tick(); drawing = 1'b1; x = 16'sd1; y = 16'sd1; cidx = 4'd1;
        tick();                 x = 16'sd2;
        tick();                 x = 16'sd3; end_in = 1'b1;
        tick(); drawing = 1'b0;
        ndone = 0; last_wr = -1; done_c = -1; busy_at_done = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (fb_we && fb_ready) last_wr = c;
            if (done) begin
                ndone++;
                done_c       = c;
                busy_at_done = busy;
            end
            tick();
        end
        end_in = 1'b0;
        chk("t5_done_once", 32'(ndone), 32'(1));
        chk("t5_last_write", 32'(last_wr), 32'(2));
        chk("t5_done_cycle", 32'(done_c), 32'(3));
        chk("t5_busy_at_done", 32'(busy_at_done), 32'(0));

        // reset with three pixels in flight
        tick(); drawing = 1'b1; x = 16'sd5; y = 16'sd5; cidx = 4'd7;
        tick();                 x = 16'sd6;
        tick();                 x = 16'sd7;
        tick(); drawing = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_oe", 32'(oe), 32'(0));
        chk("t6_rst_we", 32'(fb_we), 32'(0));
        tick(); rst = 1'b0;
        nwe = 0; ndone = 0; busy_any = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (fb_we) nwe++;
            if (done) ndone++;
            if (busy) busy_any = 1'b1;
            tick();
        end
        chk("t6_no_writes", 32'(nwe), 32'(0));
        chk("t6_no_done", 32'(ndone), 32'(0));
        chk("t6_idle", 32'(busy_any), 32'(0));

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            tick();
            rst      = ($urandom_range(0, 599) == 0);
            fb_ready = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 29) == 0) end_in = !end_in;
            if (rst) begin
                drawing = 1'b0;
            end else begin
                drawing = oe && ($urandom_range(0, 99) < 60);
            end
            if ($urandom_range(0, 7) == 0) begin
                x = 16'(edge_x[$urandom_range(0, 3)]);
                y = ($urandom_range(0, 1) == 0) ? 16'sd179 : 16'sd180;
            end else begin
                tmp = int'($urandom_range(0, 339)) - 10;
                x   = 16'(tmp);
                tmp = int'($urandom_range(0, 194)) - 5;
                y   = 16'(tmp);
            end
            cidx = 4'($urandom_range(0, 15));
        end

        tick();
        rst      = 1'b0;
        drawing  = 1'b0;
        end_in   = 1'b0;
        fb_ready = 1'b1;
        repeat (12) tick();
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
